// File: rtl/sdrc_bank_req_q_pkg.sv
// sdrc_bank_req_q_pkg
//   Shared types and widths for the SDRAM controller bank request queue.
//   `SDR_REQ_ID_W and `REQ_BW normally come from the shared sdrc_define.v.
//   The guarded fallbacks below only take effect when that file has not
//   been read first, so the slice also builds on its own.
//   Contents: field widths, the packed queue entry type entry_t, and its
//   width ENTRY_W.
`ifndef SDR_REQ_ID_W
`define SDR_REQ_ID_W 4
`endif
`ifndef REQ_BW
`define REQ_BW 12
`endif

package sdrc_bank_req_q_pkg;

   localparam int ID_W    = `SDR_REQ_ID_W;
   localparam int BA_W    = 2;
   localparam int RADDR_W = 13;
   localparam int CADDR_W = 13;
   localparam int LEN_W   = `REQ_BW;

   // One chunk request as held in the queue.
   typedef struct packed {
      logic [ID_W-1:0]    req_id;
      logic               start;
      logic               last;
      logic               wrap;
      logic               write;
      logic [BA_W-1:0]    ba;
      logic [RADDR_W-1:0] raddr;
      logic [CADDR_W-1:0] caddr;
      logic [LEN_W-1:0]   len;
   } entry_t;

   localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/sdrc_bank_req_q_mem.sv
// sdrc_bank_req_q_mem
//   DEPTH x entry_t register file for the bank request queue.
//   Ports:
//     clk      - clock, write on rising edge
//     we_i     - write enable
//     waddr_i  - write index
//     wdata_i  - entry to store
//     raddr_i  - read index (asynchronous read)
//     rdata_o  - entry at raddr_i
//   Storage is intentionally not reset; the queue pointers decide which
//   entries are meaningful.
module sdrc_bank_req_q_mem
   import sdrc_bank_req_q_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we_i,
   input  logic [AW-1:0] waddr_i,
   input  entry_t        wdata_i,
   input  logic [AW-1:0] raddr_i,
   output entry_t        rdata_o
);

   entry_t mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) begin
         mem_q[waddr_i] <= wdata_i;
      end
   end

   assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/sdrc_bank_req_q.sv
// sdrc_bank_req_q
//   FIFO of chunk requests between the request generator and a bank
//   controller.
//   Parameter: DEPTH (power of two, >= 2) queue entries.
//   Ports:
//     clk, reset_n            - clock; asynchronous active-low reset
//     r2b_req + r2b_* fields  - incoming chunk and its flags
//     b2r_ack                 - chunk accepted this cycle (req && !full)
//     b2r_arb_ok              - room for a whole request, which may be
//                               split into two chunks at a page boundary
//     q_valid / q_ready       - downstream handshake: the head entry
//                               transfers on a rising edge where both are 1;
//                               q_valid never waits on q_ready, and q_*
//                               fields are meaningless while q_valid=0
//     q_* fields              - head entry
//     q_count, q_empty        - occupancy
//   Build option: SDRC_BANK_REQ_Q_BYPASS_EN lets a chunk arriving at an
//   empty queue appear on q_* in the same cycle.
module sdrc_bank_req_q
   import sdrc_bank_req_q_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       reset_n,
   input  logic                       r2b_req,
   input  logic                       r2b_start,
   input  logic                       r2b_last,
   input  logic                       r2b_wrap,
   input  logic                       r2b_write,
   input  logic [ID_W-1:0]            r2b_req_id,
   input  logic [BA_W-1:0]            r2b_ba,
   input  logic [RADDR_W-1:0]         r2b_raddr,
   input  logic [CADDR_W-1:0]         r2b_caddr,
   input  logic [LEN_W-1:0]           r2b_len,
   output logic                       b2r_ack,
   output logic                       b2r_arb_ok,
   output logic                       q_valid,
   input  logic                       q_ready,
   output logic [ID_W-1:0]            q_req_id,
   output logic                       q_start,
   output logic                       q_last,
   output logic                       q_wrap,
   output logic                       q_write,
   output logic [BA_W-1:0]            q_ba,
   output logic [RADDR_W-1:0]         q_raddr,
   output logic [CADDR_W-1:0]         q_caddr,
   output logic [LEN_W-1:0]           q_len,
   output logic [$clog2(DEPTH):0]     q_count,
   output logic                       q_empty
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CNT_W = AW + 1;

   logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic   full;
   logic   empty;
   logic   push;
   logic   pop;
   entry_t wr_entry;
   entry_t rd_entry;
   entry_t head;

   assign wr_entry = '{req_id: r2b_req_id, start: r2b_start, last: r2b_last,
                       wrap: r2b_wrap, write: r2b_write, ba: r2b_ba,
                       raddr: r2b_raddr, caddr: r2b_caddr, len: r2b_len};

   assign full    = (count_q == CNT_W'(DEPTH));
   assign empty   = (count_q == '0);
   // A pop in the same cycle does not free a slot for this cycle's chunk.
   assign b2r_ack = r2b_req & ~full;
   assign pop     = ~empty & q_ready;

`ifdef SDRC_BANK_REQ_Q_BYPASS_EN
   // Empty queue: the incoming chunk is the head. If it is taken
   // downstream in the same cycle it is never written into storage.
   assign push    = b2r_ack & ~(empty & q_ready);
   assign q_valid = ~empty | r2b_req;
   assign head    = empty ? wr_entry : rd_entry;
`else
   assign push    = b2r_ack;
   assign q_valid = ~empty;
   assign head    = rd_entry;
`endif

   // Pointers are AW bits wide, so DEPTH being a power of two makes the
   // increment wrap from DEPTH-1 to 0 on its own.
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   sdrc_bank_req_q_mem #(
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_mem (
      .clk     (clk),
      .we_i    (push),
      .waddr_i (wr_ptr_q),
      .wdata_i (wr_entry),
      .raddr_i (rd_ptr_q),
      .rdata_o (rd_entry)
   );

   // Two free entries are kept so a page-split request fits in full.
   assign b2r_arb_ok = (count_q <= CNT_W'(DEPTH - 2));

   assign q_req_id = head.req_id;
   assign q_start  = head.start;
   assign q_last   = head.last;
   assign q_wrap   = head.wrap;
   assign q_write  = head.write;
   assign q_ba     = head.ba;
   assign q_raddr  = head.raddr;
   assign q_caddr  = head.caddr;
   assign q_len    = head.len;
   assign q_count  = count_q;
   assign q_empty  = empty;

endmodule
